wb_retire_queue: RTL and testbench

//  Parametrised write-back stage: an in-order DEPTH-entry retire queue between MEM and the regfile/CSR file.

---
 rtl/wb_retire_queue_if.sv | 35 +++
 rtl/wb_retire_queue.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_retire_queue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_queue_if.sv
// MEM -> WB handshake and payload bundle for the write-back retire queue.
// The MEM stage drives the payload through the master modport.
// The retire queue receives it through the slave modport and returns ws_allowin.
interface wb_retire_queue_if #(
   parameter int DATA_W = 32,
   parameter int RF_AW  = 5
);
   logic              ms_to_ws_valid;
   logic              ws_allowin;
   logic [DATA_W-1:0] ms_pc;
   logic [DATA_W-1:0] ms_result;
   logic              ms_gr_we;
   logic [RF_AW-1:0]  ms_dest;
   logic              ms_csr_we;
   logic              ms_csr_re;
   logic [13:0]       ms_csr_wnum;
   logic [DATA_W-1:0] ms_csr_wmask;
   logic [DATA_W-1:0] ms_csr_wd;
   logic              ms_ertn;
   logic [5:0]        ms_exc_flgs;

   modport master (
      output ms_to_ws_valid, ms_pc, ms_result, ms_gr_we, ms_dest,
             ms_csr_we, ms_csr_re, ms_csr_wnum, ms_csr_wmask, ms_csr_wd,
             ms_ertn, ms_exc_flgs,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid, ms_pc, ms_result, ms_gr_we, ms_dest,
             ms_csr_we, ms_csr_re, ms_csr_wnum, ms_csr_wmask, ms_csr_wd,
             ms_ertn, ms_exc_flgs,
      output ws_allowin
   );
endinterface

// File: rtl/wb_retire_queue.sv
// In-order DEPTH-entry write-back retire queue between MEM and the regfile/CSR file.
// The head entry commits GR/CSR writes, reports exceptions or ertn, and drives the trace port.
// Every queued entry, head included, feeds GR forwarding and CSR-hazard information back to ID.
// Optional feature macro: WB_DBG_HANDSHAKE_EN adds i_debug_wb_ready, which gates head retirement.
module wb_retire_queue #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32,
   parameter int RF_AW  = 5
) (
   input  logic              clk,
   input  logic              reset,
`ifdef WB_DBG_HANDSHAKE_EN
   input  logic              i_debug_wb_ready,
`endif
   wb_retire_queue_if.slave  ms_if,
   output logic              o_rf_we,
   output logic [RF_AW-1:0]  o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_csr_we,
   output logic [13:0]       o_csr_wnum,
   output logic [DATA_W-1:0] o_csr_wmask,
   output logic [DATA_W-1:0] o_csr_wval,
   output logic              o_wb_exc,
   output logic [5:0]        o_wb_ecode,
   output logic [8:0]        o_wb_esubcode,
   output logic [DATA_W-1:0] o_wb_pc,
   output logic              o_ertn_flush,
   input  logic [RF_AW-1:0]  i_qry_addr0,
   input  logic [RF_AW-1:0]  i_qry_addr1,
   output logic              o_qry_hit0,
   output logic              o_qry_hit1,
   output logic [DATA_W-1:0] o_qry_data0,
   output logic [DATA_W-1:0] o_qry_data1,
   output logic              o_csr_blk,
   output logic [13:0]       o_csr_blk_wnum,
   output logic [DATA_W-1:0] o_debug_wb_pc,
   output logic [3:0]        o_debug_wb_rf_wen,
   output logic [RF_AW-1:0]  o_debug_wb_rf_wnum,
   output logic [DATA_W-1:0] o_debug_wb_rf_wdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Pointer advance with wrap at DEPTH (also covers the single-entry case).
   function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_W'(DEPTH - 1)) begin
         n = '0;
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   // Exception code of the lowest-index raised flag.
   function automatic logic [5:0] f_ecode(input logic [5:0] flgs);
      logic [5:0] c;
      casez (flgs)
         6'b?????1: c = 6'h00;   // INT
         6'b????10: c = 6'h08;   // ADEF
         6'b???100: c = 6'h0D;   // INE
         6'b??1000: c = 6'h0B;   // SYS
         6'b?10000: c = 6'h0C;   // BRK
         6'b100000: c = 6'h09;   // ALE
         default:   c = 6'h00;
      endcase
      return c;
   endfunction

   // Queue bookkeeping
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DEPTH-1:0]  r_valid;

   // Entry payload
   logic [DATA_W-1:0] r_pc       [DEPTH];
   logic [DATA_W-1:0] r_result   [DEPTH];
   logic              r_gr_we    [DEPTH];
   logic [RF_AW-1:0]  r_dest     [DEPTH];
   logic              r_csr_we   [DEPTH];
   logic              r_csr_re   [DEPTH];
   logic [13:0]       r_csr_wnum [DEPTH];
   logic [DATA_W-1:0] r_csr_wmask[DEPTH];
   logic [DATA_W-1:0] r_csr_wd   [DEPTH];
   logic              r_ertn     [DEPTH];
   logic [5:0]        r_flgs     [DEPTH];

   logic              w_ready_go;
   logic              w_head_valid;
   logic              w_head_exc;
   logic              w_retire;
   logic              w_flush;
   logic              w_allowin;
   logic              w_enq;
   logic              w_commit_ok;
   logic [DATA_W-1:0] w_head_wdata;
   logic [PTR_W-1:0]  w_idx;

`ifdef WB_DBG_HANDSHAKE_EN
   assign w_ready_go = i_debug_wb_ready;
`else
   assign w_ready_go = 1'b1;
`endif

   // Reset suppresses retirement so a mid-operation reset never commits.
   assign w_head_valid = r_valid[r_rd_ptr];
   assign w_head_exc   = |r_flgs[r_rd_ptr];
   assign w_retire     = w_head_valid & w_ready_go & ~reset;
   assign w_flush      = w_retire & (w_head_exc | r_ertn[r_rd_ptr]);
   assign w_allowin    = (r_count < DEPTH_C) | w_retire;
   assign w_enq        = ms_if.ms_to_ws_valid & w_allowin & ~w_flush;
   assign w_commit_ok  = w_retire & ~w_head_exc;
   assign w_head_wdata = r_csr_re[r_rd_ptr] ? r_csr_wd[r_rd_ptr] : r_result[r_rd_ptr];

   assign ms_if.ws_allowin = w_allowin;

   // Head commit, exception report and trace outputs.
   assign o_rf_we             = w_commit_ok & r_gr_we[r_rd_ptr];
   assign o_rf_waddr          = r_dest[r_rd_ptr];
   assign o_rf_wdata          = w_head_wdata;
   assign o_csr_we            = w_commit_ok & r_csr_we[r_rd_ptr];
   assign o_csr_wnum          = r_csr_wnum[r_rd_ptr];
   assign o_csr_wmask         = r_csr_wmask[r_rd_ptr];
   assign o_csr_wval          = r_csr_wd[r_rd_ptr];
   assign o_ertn_flush        = w_commit_ok & r_ertn[r_rd_ptr];
   assign o_wb_exc            = w_retire & w_head_exc;
   assign o_wb_ecode          = o_wb_exc ? f_ecode(r_flgs[r_rd_ptr]) : 6'h00;
   assign o_wb_esubcode       = 9'h000;
   assign o_wb_pc             = r_pc[r_rd_ptr];
   assign o_debug_wb_pc       = r_pc[r_rd_ptr];
   assign o_debug_wb_rf_wen   = {4{o_rf_we}};
   assign o_debug_wb_rf_wnum  = r_dest[r_rd_ptr];
   assign o_debug_wb_rf_wdata = w_head_wdata;

   // Forwarding and CSR-hazard search: walk oldest to youngest so the youngest match wins.
   always_comb begin
      o_qry_hit0     = 1'b0;
      o_qry_hit1     = 1'b0;
      o_qry_data0    = '0;
      o_qry_data1    = '0;
      o_csr_blk      = 1'b0;
      o_csr_blk_wnum = 14'h0000;
      w_idx          = r_rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rd_ptr + PTR_W'(k);
         if (r_valid[w_idx] && r_gr_we[w_idx] && (r_flgs[w_idx] == 6'b000000)
             && (r_dest[w_idx] == i_qry_addr0) && (i_qry_addr0 != '0)) begin
            o_qry_hit0  = 1'b1;
            o_qry_data0 = r_csr_re[w_idx] ? r_csr_wd[w_idx] : r_result[w_idx];
         end else begin
            o_qry_hit0  = o_qry_hit0;
         end
         if (r_valid[w_idx] && r_gr_we[w_idx] && (r_flgs[w_idx] == 6'b000000)
             && (r_dest[w_idx] == i_qry_addr1) && (i_qry_addr1 != '0)) begin
            o_qry_hit1  = 1'b1;
            o_qry_data1 = r_csr_re[w_idx] ? r_csr_wd[w_idx] : r_result[w_idx];
         end else begin
            o_qry_hit1  = o_qry_hit1;
         end
         if (r_valid[w_idx] && (r_csr_we[w_idx] || r_ertn[w_idx])) begin
            o_csr_blk      = 1'b1;
            o_csr_blk_wnum = r_csr_wnum[w_idx];
         end else begin
            o_csr_blk      = o_csr_blk;
         end
      end
   end

   // Queue state: reset and flush empty it; otherwise retire from the head and enqueue at the tail.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]        <= '0;
            r_result[i]    <= '0;
            r_gr_we[i]     <= 1'b0;
            r_dest[i]      <= '0;
            r_csr_we[i]    <= 1'b0;
            r_csr_re[i]    <= 1'b0;
            r_csr_wnum[i]  <= 14'h0000;
            r_csr_wmask[i] <= '0;
            r_csr_wd[i]    <= '0;
            r_ertn[i]      <= 1'b0;
            r_flgs[i]      <= 6'b000000;
         end
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         // Retire is applied before enqueue so a full queue can refill the freed slot.
         if (w_retire) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= f_next_ptr(r_rd_ptr);
         end
         if (w_enq) begin
            r_valid[r_wr_ptr]     <= 1'b1;
            r_wr_ptr              <= f_next_ptr(r_wr_ptr);
            r_pc[r_wr_ptr]        <= ms_if.ms_pc;
            r_result[r_wr_ptr]    <= ms_if.ms_result;
            r_gr_we[r_wr_ptr]     <= ms_if.ms_gr_we;
            r_dest[r_wr_ptr]      <= ms_if.ms_dest;
            r_csr_we[r_wr_ptr]    <= ms_if.ms_csr_we;
            r_csr_re[r_wr_ptr]    <= ms_if.ms_csr_re;
            r_csr_wnum[r_wr_ptr]  <= ms_if.ms_csr_wnum;
            r_csr_wmask[r_wr_ptr] <= ms_if.ms_csr_wmask;
            r_csr_wd[r_wr_ptr]    <= ms_if.ms_csr_wd;
            r_ertn[r_wr_ptr]      <= ms_if.ms_ertn;
            r_flgs[r_wr_ptr]      <= ms_if.ms_exc_flgs;
         end
         case ({w_enq, w_retire})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Randomised self-checking bench for wb_retire_queue against a queue-based reference model.
module tb_wb_retire_queue;

   localparam int DEPTH  = 2;
   localparam int DATA_W = 32;
   localparam int RF_AW  = 5;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] result;
      logic        gr_we;
      logic [4:0]  dest;
      logic        csr_we;
      logic        csr_re;
      logic [13:0] wnum;
      logic [31:0] wmask;
      logic [31:0] wd;
      logic        ertn;
      logic [5:0]  flgs;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rdy = 1'b1;
   logic [4:0]  qa0 = 5'd0;
   logic [4:0]  qa1 = 5'd0;

   logic        rf_we, csr_we, wb_exc, ertn_flush, hit0, hit1, csr_blk;
   logic [4:0]  rf_waddr, dbg_wnum;
   logic [31:0] rf_wdata, csr_wmask, csr_wval, wb_pc, qd0, qd1, dbg_pc, dbg_wdata;
   logic [13:0] csr_wnum, blk_wnum;
   logic [5:0]  ecode;
   logic [8:0]  esub;
   logic [3:0]  dbg_wen;

   wb_retire_queue_if #(.DATA_W(DATA_W), .RF_AW(RF_AW)) bus();

   wb_retire_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RF_AW(RF_AW)) dut (
      .clk                 (clk),
      .reset               (reset),
`ifdef WB_DBG_HANDSHAKE_EN
      .i_debug_wb_ready    (rdy),
`endif
      .ms_if               (bus),
      .o_rf_we             (rf_we),
      .o_rf_waddr          (rf_waddr),
      .o_rf_wdata          (rf_wdata),
      .o_csr_we            (csr_we),
      .o_csr_wnum          (csr_wnum),
      .o_csr_wmask         (csr_wmask),
      .o_csr_wval          (csr_wval),
      .o_wb_exc            (wb_exc),
      .o_wb_ecode          (ecode),
      .o_wb_esubcode       (esub),
      .o_wb_pc             (wb_pc),
      .o_ertn_flush        (ertn_flush),
      .i_qry_addr0         (qa0),
      .i_qry_addr1         (qa1),
      .o_qry_hit0          (hit0),
      .o_qry_hit1          (hit1),
      .o_qry_data0         (qd0),
      .o_qry_data1         (qd1),
      .o_csr_blk           (csr_blk),
      .o_csr_blk_wnum      (blk_wnum),
      .o_debug_wb_pc       (dbg_pc),
      .o_debug_wb_rf_wen   (dbg_wen),
      .o_debug_wb_rf_wnum  (dbg_wnum),
      .o_debug_wb_rf_wdata (dbg_wdata)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t q[$];
   ent_t cur;
   logic cur_v = 1'b0;

   // Snapshot of DUT outputs from the most recent checked cycle
   logic        s_allow, s_rf_we, s_csr_we, s_exc, s_ertn, s_hit0, s_hit1, s_blk;
   logic [4:0]  s_waddr;
   logic [31:0] s_wdata, s_pc, s_qd0, s_dbg_pc;
   logic [13:0] s_blk_wnum;
   logic [5:0]  s_ecode;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic [4:0] dest, input logic [31:0] val, input logic [31:0] pc);
      ent_t e;
      e.pc = pc; e.result = val; e.gr_we = 1'b1; e.dest = dest;
      e.csr_we = 1'b0; e.csr_re = 1'b0; e.wnum = 14'h0; e.wmask = 32'h0; e.wd = 32'h0;
      e.ertn = 1'b0; e.flgs = 6'b0;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e;
      e.pc     = $urandom;
      e.result = $urandom;
      e.gr_we  = ($urandom_range(0, 3) != 0);
      e.dest   = 5'($urandom_range(0, 7));
      e.csr_we = ($urandom_range(0, 7) == 0);
      e.csr_re = ($urandom_range(0, 5) == 0);
      e.wnum   = 14'($urandom_range(0, 15));
      e.wmask  = $urandom;
      e.wd     = $urandom;
      e.ertn   = ($urandom_range(0, 31) == 0);
      e.flgs   = ($urandom_range(0, 11) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      return e;
   endfunction

   task automatic set_in(input logic v, input ent_t e);
      cur   = e;
      cur_v = v;
      bus.ms_to_ws_valid = v;
      bus.ms_pc          = e.pc;
      bus.ms_result      = e.result;
      bus.ms_gr_we       = e.gr_we;
      bus.ms_dest        = e.dest;
      bus.ms_csr_we      = e.csr_we;
      bus.ms_csr_re      = e.csr_re;
      bus.ms_csr_wnum    = e.wnum;
      bus.ms_csr_wmask   = e.wmask;
      bus.ms_csr_wd      = e.wd;
      bus.ms_ertn        = e.ertn;
      bus.ms_exc_flgs    = e.flgs;
   endtask

   function automatic logic [5:0] ref_ecode(input logic [5:0] f);
      logic [5:0] tbl [6];
      logic [5:0] c;
      tbl = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
      c = 6'h00;
      for (int i = 5; i >= 0; i--) if (f[i]) c = tbl[i];
      return c;
   endfunction

   // One clock cycle: compare DUT against the model, advance the model, then clock.
   task automatic tick();
      int   n;
      bit   ret, exc, ertn, flush, allow, hit, blk;
      ent_t h;
      logic [31:0] hw, d;
      logic [13:0] bw;
      logic [4:0]  a;
      #1;
      n   = q.size();
      ret = (n > 0) && rdy && !reset;
      if (n > 0) h = q[0]; else h = mk(5'd0, 32'd0, 32'd0);
      exc   = ret && (h.flgs != 6'd0);
      ertn  = ret && h.ertn && (h.flgs == 6'd0);
      allow = (n < DEPTH) || ret;
      hw    = h.csr_re ? h.wd : h.result;

      chk("ws_allowin", bus.ws_allowin, allow);
      chk("rf_we", rf_we, ret && h.gr_we && !exc);
      chk("dbg_wen", dbg_wen, {4{ret && h.gr_we && !exc}});
      if (ret && h.gr_we && !exc) begin
         chk("rf_waddr", rf_waddr, h.dest);
         chk("rf_wdata", rf_wdata, hw);
      end
      chk("csr_we", csr_we, ret && h.csr_we && !exc);
      if (ret && h.csr_we && !exc) begin
         chk("csr_wnum", csr_wnum, h.wnum);
         chk("csr_wmask", csr_wmask, h.wmask);
         chk("csr_wval", csr_wval, h.wd);
      end
      chk("wb_exc", wb_exc, exc);
      if (exc) begin
         chk("ecode", ecode, ref_ecode(h.flgs));
         chk("esubcode", esub, 9'd0);
         chk("wb_pc", wb_pc, h.pc);
      end
      chk("ertn_flush", ertn_flush, ertn);
      if (ret) begin
         chk("dbg_pc", dbg_pc, h.pc);
         chk("dbg_wnum", dbg_wnum, h.dest);
         chk("dbg_wdata", dbg_wdata, hw);
      end
      for (int p = 0; p < 2; p++) begin
         a = (p == 0) ? qa0 : qa1;
         hit = 1'b0; d = 32'd0;
         for (int i = n - 1; i >= 0; i--)
            if (!hit && q[i].gr_we && q[i].flgs == 6'd0 && q[i].dest == a && a != 5'd0) begin
               hit = 1'b1;
               d = q[i].csr_re ? q[i].wd : q[i].result;
            end
         chk(p == 0 ? "qry_hit0" : "qry_hit1", p == 0 ? hit0 : hit1, hit);
         if (hit) chk(p == 0 ? "qry_data0" : "qry_data1", p == 0 ? qd0 : qd1, d);
      end
      blk = 1'b0; bw = 14'd0;
      for (int i = n - 1; i >= 0; i--)
         if (!blk && (q[i].csr_we || q[i].ertn)) begin blk = 1'b1; bw = q[i].wnum; end
      chk("csr_blk", csr_blk, blk);
      if (blk) chk("csr_blk_wnum", blk_wnum, bw);

      s_allow = bus.ws_allowin; s_rf_we = rf_we; s_csr_we = csr_we; s_exc = wb_exc;
      s_ertn = ertn_flush; s_hit0 = hit0; s_hit1 = hit1; s_blk = csr_blk;
      s_waddr = rf_waddr; s_wdata = rf_wdata; s_pc = wb_pc; s_qd0 = qd0;
      s_dbg_pc = dbg_pc; s_blk_wnum = blk_wnum; s_ecode = ecode;

      flush = ret && ((h.flgs != 6'd0) || h.ertn);
      if (reset || flush) begin
         q.delete();
      end else begin
         if (ret) void'(q.pop_front());
         if (cur_v && allow) q.push_back(cur);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   ent_t e;

   initial begin
      set_in(1'b0, mk(5'd0, 32'd0, 32'd0));
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("rst_allowin", s_allow, 1'b1);
      chk("rst_rf_we", s_rf_we, 1'b0);
      chk("rst_dbg_pc", s_dbg_pc, 32'h0);
      chk("rst_csr_blk", s_blk, 1'b0);
      chk("rst_wb_exc", s_exc, 1'b0);

      // Back-to-back adds
      set_in(1'b1, mk(5'd4, 32'h11, 32'h1C000000)); tick();
      chk("t1_allow0", s_allow, 1'b1);
      set_in(1'b1, mk(5'd5, 32'h22, 32'h1C000004)); tick();
      chk("t1_we_a", s_rf_we, 1'b1); chk("t1_addr_a", s_waddr, 5'd4); chk("t1_data_a", s_wdata, 32'h11);
      chk("t1_allow1", s_allow, 1'b1);
      set_in(1'b1, mk(5'd6, 32'h33, 32'h1C000008)); tick();
      chk("t1_addr_b", s_waddr, 5'd5); chk("t1_data_b", s_wdata, 32'h22); chk("t1_allow2", s_allow, 1'b1);
      set_in(1'b0, mk(5'd0, 32'h0, 32'h0)); tick();
      chk("t1_we_c", s_rf_we, 1'b1); chk("t1_addr_c", s_waddr, 5'd6); chk("t1_data_c", s_wdata, 32'h33);
      tick();
      chk("t1_idle", s_rf_we, 1'b0);

      // Exception at head; the younger entry is dropped
      e = mk(5'd8, 32'h88, 32'h1C000010); e.flgs = 6'b000110;
      set_in(1'b1, e); tick();
      set_in(1'b1, mk(5'd9, 32'h99, 32'h1C000014)); tick();
      chk("t3_exc", s_exc, 1'b1); chk("t3_ecode", s_ecode, 6'h08);
      chk("t3_pc", s_pc, 32'h1C000010); chk("t3_rf_we", s_rf_we, 1'b0);
      set_in(1'b0, mk(5'd0, 32'h0, 32'h0)); tick();
      chk("t3_young", s_rf_we, 1'b0); chk("t3_exc_off", s_exc, 1'b0);

      // ertn at head with a csr write offered behind it
      e = mk(5'd0, 32'h0, 32'h1C000020); e.gr_we = 1'b0; e.ertn = 1'b1;
      set_in(1'b1, e); tick();
      e = mk(5'd0, 32'h0, 32'h1C000024); e.gr_we = 1'b0; e.csr_we = 1'b1; e.wnum = 14'h005;
      set_in(1'b1, e); tick();
      chk("t4_ertn", s_ertn, 1'b1); chk("t4_csr_we", s_csr_we, 1'b0);
      set_in(1'b0, mk(5'd0, 32'h0, 32'h0)); tick();
      chk("t4_ertn_once", s_ertn, 1'b0); chk("t4_csr_never", s_csr_we, 1'b0);

      // Forwarding of r7
      qa0 = 5'd7; qa1 = 5'd0;
`ifdef WB_DBG_HANDSHAKE_EN
      rdy = 1'b0;
      set_in(1'b1, mk(5'd7, 32'hA, 32'h1C000030)); tick();
      set_in(1'b1, mk(5'd7, 32'hB, 32'h1C000034)); tick();
      e = mk(5'd0, 32'h0, 32'h1C000038); e.gr_we = 1'b0; e.csr_we = 1'b1; e.wnum = 14'h005;
      set_in(1'b1, e); tick();
      chk("t2_full", s_allow, 1'b0); chk("t5_hit0", s_hit0, 1'b1); chk("t5_data0", s_qd0, 32'hB);
      chk("t5_hit1", s_hit1, 1'b0); chk("t2_stall", s_rf_we, 1'b0);
      rdy = 1'b1; tick();
      chk("t2_allow", s_allow, 1'b1); chk("t2_retire", s_rf_we, 1'b1); chk("t2_data", s_wdata, 32'hA);
      rdy = 1'b0; set_in(1'b0, mk(5'd0, 32'h0, 32'h0)); tick();
      chk("t6_blk", s_blk, 1'b1); chk("t6_wnum", s_blk_wnum, 14'h005);
      rdy = 1'b1; tick(); tick();
      chk("t6_csr_we", s_csr_we, 1'b1);
      tick();
      chk("t6_blk_off", s_blk, 1'b0);
`else
      set_in(1'b1, mk(5'd7, 32'hA, 32'h1C000030)); tick();
      chk("t5_empty", s_hit0, 1'b0);
      set_in(1'b1, mk(5'd7, 32'hB, 32'h1C000034)); tick();
      chk("t5_hit_a", s_hit0, 1'b1); chk("t5_data_a", s_qd0, 32'hA); chk("t5_hit1", s_hit1, 1'b0);
      e = mk(5'd0, 32'h0, 32'h1C000038); e.gr_we = 1'b0; e.csr_we = 1'b1; e.wnum = 14'h005;
      set_in(1'b1, e); tick();
      chk("t5_hit_b", s_hit0, 1'b1); chk("t5_data_b", s_qd0, 32'hB);
      set_in(1'b0, mk(5'd0, 32'h0, 32'h0)); tick();
      chk("t6_blk", s_blk, 1'b1); chk("t6_wnum", s_blk_wnum, 14'h005); chk("t6_csr_we", s_csr_we, 1'b1);
      tick();
      chk("t6_blk_off", s_blk, 1'b0);
`endif

      // Reset while an entry is at the head
      set_in(1'b1, mk(5'd3, 32'h3333, 32'h1C000040)); tick();
      set_in(1'b0, mk(5'd0, 32'h0, 32'h0)); reset = 1'b1; tick();
      chk("rst_mid_no_commit", s_rf_we, 1'b0);
      reset = 1'b0; tick();
      chk("rst_mid_empty", s_rf_we, 1'b0); chk("rst_mid_allow", s_allow, 1'b1);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
`ifdef WB_DBG_HANDSHAKE_EN
         rdy = ($urandom_range(0, 3) != 0);
`endif
         qa0 = 5'($urandom_range(0, 7));
         qa1 = 5'($urandom_range(0, 7));
         set_in($urandom_range(0, 3) != 0, rnd_ent());
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
